// File: rtl/fft_pkg.sv
// Shared types, constants and fixed-point helpers for the radix-2 SDF FFT stages.
package fft_pkg;

  localparam int DIN_W     = 15;
  localparam int DOUT_W    = DIN_W + 1;
  localparam int DELAY     = 4;
  localparam int COEF      = 181;
  localparam int COEF_FRAC = 8;
  // Headroom for a DIN_W+2 operand times a 9-bit signed coefficient, plus negation.
  localparam int PROD_W    = DOUT_W + 2 + COEF_FRAC + 1;

  typedef logic signed [PROD_W-1:0] wide_t;

  typedef struct packed {
    logic signed [DOUT_W-1:0] r;
    logic signed [DOUT_W-1:0] i;
  } cplx_t;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam wide_t RND_HALF = wide_t'(2 ** (COEF_FRAC - 1));
  localparam wide_t SAT_MAX  = wide_t'(2 ** (DOUT_W - 1) - 1);
  localparam wide_t SAT_MIN  = wide_t'(-(2 ** (DOUT_W - 1)));

  function automatic wide_t round_prod(input wide_t p);
    return (p + RND_HALF) >>> COEF_FRAC;
  endfunction

  function automatic logic signed [DOUT_W-1:0] sat_out(input wide_t v);
    if (v > SAT_MAX) return SAT_MAX[DOUT_W-1:0];
    if (v < SAT_MIN) return SAT_MIN[DOUT_W-1:0];
    return v[DOUT_W-1:0];
  endfunction

endpackage

// File: rtl/fft_stage3_if.sv
// Stream bus between STAGE2, fft_stage3 and STAGE4 (15-bit in, 16-bit out).
interface fft_stage3_if;
  import fft_pkg::*;

  logic                     valid_i;
  logic signed [DIN_W-1:0]  data_in_r;
  logic signed [DIN_W-1:0]  data_in_i;
  logic                     valid_o;
  logic signed [DOUT_W-1:0] data_out_r;
  logic signed [DOUT_W-1:0] data_out_i;

  modport master (
    output valid_i, data_in_r, data_in_i,
    input  valid_o, data_out_r, data_out_i
  );

  modport slave (
    input  valid_i, data_in_r, data_in_i,
    output valid_o, data_out_r, data_out_i
  );
endinterface

// File: rtl/fft_rot_w8.sv
// Combinational W8^k twiddle rotator with rounding and output saturation.
module fft_rot_w8
  import fft_pkg::*;
(
  input  logic [1:0] k,
  input  cplx_t      x,
  output cplx_t      y
);

  localparam wide_t CW = wide_t'(COEF);

  wide_t xr, xi, s, d;

  always_comb begin
    xr = wide_t'(x.r);
    xi = wide_t'(x.i);
    s  = xr + xi;
    d  = xi - xr;
    y  = '0;
    case (k)
      2'd0: begin
        y.r = sat_out(xr);
        y.i = sat_out(xi);
      end
      2'd1: begin
        y.r = sat_out(round_prod(CW * s));
        y.i = sat_out(round_prod(CW * d));
      end
      2'd2: begin
        y.r = sat_out(xi);
        y.i = sat_out(-xr);
      end
      default: begin
        // c*(-r-i) formed as -(c*(r+i)) before rounding; identical value, no extra operand bit.
        y.r = sat_out(round_prod(CW * d));
        y.i = sat_out(round_prod(-(CW * s)));
      end
    endcase
  end

endmodule

// File: rtl/fft_stage3.sv
// Third R2SDF DIF stage: span-4 butterflies through a 4-deep feedback line, W8^k on differences.
module fft_stage3
  import fft_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,  // active-high despite the legacy name
  fft_stage3_if.slave   bus
);

  state_t     state_q, state_d;
  logic [2:0] n_q, n_d;
  logic       has_diff_q, has_diff_d;
  logic       valid_o_q, valid_o_d;
  cplx_t      out_q, out_d;
  cplx_t      dl_q [DELAY];
  cplx_t      dl_d [DELAY];
  cplx_t      head, in_c, push_c, rot_y;
  logic       shift;

  assign head = dl_q[DELAY-1];

  fft_rot_w8 u_rot (
    .k (n_q[1:0]),
    .x (head),
    .y (rot_y)
  );

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    has_diff_d = has_diff_q;
    valid_o_d  = 1'b0;
    out_d      = out_q;
    shift      = 1'b0;
    push_c     = '0;
    in_c.r     = {bus.data_in_r[DIN_W-1], bus.data_in_r};
    in_c.i     = {bus.data_in_i[DIN_W-1], bus.data_in_i};

    case (state_q)
      IDLE, RUN: begin
        if (bus.valid_i) begin
          shift   = 1'b1;
          state_d = RUN;
          n_d     = n_q + 3'd1;
          if (!n_q[2]) begin
            push_c    = in_c;
            out_d     = rot_y;
            valid_o_d = has_diff_q;
            if (n_q == 3'd3) has_diff_d = 1'b0;
          end else begin
            push_c.r  = head.r - in_c.r;
            push_c.i  = head.i - in_c.i;
            out_d.r   = head.r + in_c.r;
            out_d.i   = head.i + in_c.i;
            valid_o_d = 1'b1;
            if (n_q == 3'd7) has_diff_d = 1'b1;
          end
        end else if (state_q == RUN && n_q == 3'd0) begin
          // The first stored difference leaves in the decision cycle so the frame output stays contiguous.
          if (has_diff_q) begin
            shift     = 1'b1;
            out_d     = rot_y;
            valid_o_d = 1'b1;
            n_d       = 3'd1;
            state_d   = FLUSH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        shift     = 1'b1;
        out_d     = rot_y;
        valid_o_d = 1'b1;
        n_d       = n_q + 3'd1;
        if (n_q == 3'd3) begin
          state_d    = IDLE;
          n_d        = '0;
          has_diff_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    dl_d = dl_q;
    if (shift) begin
      dl_d[0] = push_c;
      for (int unsigned j = 1; j < DELAY; j++) dl_d[j] = dl_q[j-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      has_diff_q <= 1'b0;
      valid_o_q  <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      has_diff_q <= has_diff_d;
      valid_o_q  <= valid_o_d;
      out_q      <= out_d;
    end
    dl_q <= dl_d;
  end

  assign bus.valid_o    = valid_o_q;
  assign bus.data_out_r = out_q.r;
  assign bus.data_out_i = out_q.i;

endmodule
